vt52_rx_fifo: RTL and testbench

Byte FIFO between the USB UART receive pipeline (`uart_out_*`) and the command handler. It decouples bursty host traffic from command-handler stalls, such as scroll and clear operations. It uses valid/ready handshakes on both sides, first-word-fall-through output, and an occupancy count. All logic runs in the 48 MHz `fast_clk` domain inside `top`.

---
 rtl/vt52_rx_fifo.sv | 90 +++++++++
 tb/tb_vt52_rx_fifo.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vt52_rx_fifo.sv
// vt52_rx_fifo: first-word-fall-through byte FIFO between the USB UART receiver and the command handler.
// Optional high-water-mark register enabled by defining VT52_RX_FIFO_HWM_EN.
module vt52_rx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int DEPTH_BITS  = 4,
    parameter int ALMOST_FULL = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_BITS-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_BITS-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_BITS:0]   level,
    output logic                  almost_full,
    output logic [DEPTH_BITS:0]   hwm,
    input  logic                  hwm_clear
);

    localparam logic [DEPTH_BITS:0] DEPTH_L  = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [DEPTH_BITS:0] AF_LEVEL = ALMOST_FULL[DEPTH_BITS:0];

    logic [DATA_BITS-1:0]  mem [0:(1<<DEPTH_BITS)-1];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic [DEPTH_BITS:0]   count_next;
    logic                  push;
    logic                  pop;

    // reset_n gates in_ready so no handshake can complete while reset is held
    assign in_ready  = (count != DEPTH_L) & reset_n;
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign level     = count;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + (DEPTH_BITS+1)'(1);
        else if (pop && !push)
            count_next = count - (DEPTH_BITS+1)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (DEPTH_BITS)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (DEPTH_BITS)'(1);
            count       <= count_next;
            almost_full <= (count_next >= AF_LEVEL);
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

`ifdef VT52_RX_FIFO_HWM_EN
    logic [DEPTH_BITS:0] hwm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hwm_q <= '0;
        else if (hwm_clear || (count_next > hwm_q))
            hwm_q <= count_next;
    end

    assign hwm = hwm_q;
`else
    logic unused_hwm_clear;

    assign unused_hwm_clear = hwm_clear;
    assign hwm              = '0;
`endif

endmodule

// File: tb/tb_vt52_rx_fifo.sv
// Directed self-checking bench for vt52_rx_fifo (default build and VT52_RX_FIFO_HWM_EN build).
module tb_vt52_rx_fifo;

`ifdef VT52_RX_FIFO_HWM_EN
    localparam int HWM_ON = 1;
`else
    localparam int HWM_ON = 0;
`endif

    logic       clk;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] level;
    logic       almost_full;
    logic [4:0] hwm;
    logic       hwm_clear;

    int checks;
    int failures;

    vt52_rx_fifo #(
        .DATA_BITS  (8),
        .DEPTH_BITS (4),
        .ALMOST_FULL(12)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .almost_full(almost_full),
        .hwm        (hwm),
        .hwm_clear  (hwm_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        hwm_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
        checks++; if (hwm !== 5'd0) begin failures++; $display("FAIL reset_hwm got=%0d exp=0", hwm); end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL release_level got=%0d exp=0", level); end
    endtask

    task automatic test_latency();
        in_valid = 1'b1;
        in_data  = 8'h41;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_empty_valid got=%b exp=0", out_valid); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'h41) begin failures++; $display("FAIL lat_out_data got=%h exp=41", out_data); end
        checks++; if (level !== 5'd1) begin failures++; $display("FAIL lat_level got=%0d exp=1", level); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_pop_valid got=%b exp=0", out_valid); end
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL lat_pop_level got=%0d exp=0", level); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, in_ready); end
            step();
            checks++; if (level !== 5'(i + 1)) begin failures++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, i + 1); end
            checks++;
            if (almost_full !== (i + 1 >= 12)) begin
                failures++; $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, almost_full, (i + 1 >= 12));
            end
        end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        in_data = 8'hFF;
        repeat (3) step();
        checks++; if (level !== 5'd16) begin failures++; $display("FAIL full_holdoff_level got=%0d exp=16", level); end
        in_valid = 1'b0;
        // First drain cycle: pop while full must not raise in_ready in the same cycle
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_no_passthru got=%b exp=0", in_ready); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_data !== 8'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, out_data, 8'(i)); end
            step();
            checks++;
            if (almost_full !== (15 - i >= 12)) begin
                failures++; $display("FAIL drain_almost_full[%0d] got=%b exp=%b", i, almost_full, (15 - i >= 12));
            end
            if (i == 0) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL unfull_in_ready got=%b exp=1", in_ready); end
            end
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
        checks++; if (in_data !== 8'hFF || level !== 5'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", level); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h50 + i);
            step();
        end
        checks++; if (level !== 5'd5) begin failures++; $display("FAIL b2b_prefill got=%0d exp=5", level); end
        for (int k = 0; k < 20; k++) begin
            in_valid  = 1'b1;
            in_data   = 8'(8'h55 + k);
            out_ready = 1'b1;
            checks++; if (out_data !== 8'(8'h50 + k)) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, out_data, 8'(8'h50 + k)); end
            step();
            checks++; if (level !== 5'd5) begin failures++; $display("FAIL b2b_level[%0d] got=%0d exp=5", k, level); end
        end
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            checks++; if (out_data !== 8'(8'h64 + j)) begin failures++; $display("FAIL b2b_tail[%0d] got=%h exp=%h", j, out_data, 8'(8'h64 + j)); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL b2b_end_level got=%0d exp=0", level); end
    endtask

    task automatic test_random_stream();
        int sent;
        int got;
        int model;
        bit do_push;
        bit do_pop;
        sent  = 0;
        got   = 0;
        model = 0;
        for (int cyc = 0; cyc < 2000 && got < 40; cyc++) begin
            in_valid  = (sent < 40) && ($urandom_range(0, 2) != 0);
            in_data   = 8'(sent);
            out_ready = ($urandom_range(0, 3) == 0) ? 1'b1 : (model > 10);
            #1;
            checks++; if (in_ready !== (model != 16)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (model != 16)); end
            checks++; if (out_valid !== (model != 0)) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, (model != 0)); end
            do_push = in_valid && (model != 16);
            do_pop  = out_ready && (model != 0);
            if (do_pop) begin
                checks++; if (out_data !== 8'(got)) begin failures++; $display("FAIL rnd_data[%0d] got=%h exp=%h", got, out_data, 8'(got)); end
                got++;
            end
            if (do_push) sent++;
            model = model + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
            step();
            checks++; if (level !== 5'(model)) begin failures++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", cyc, level, model); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (got !== 40) begin failures++; $display("FAIL rnd_count got=%0d exp=40", got); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            step();
        end
        in_valid = 1'b0;
        checks++; if (level !== 5'd7) begin failures++; $display("FAIL mid_prefill got=%0d exp=7", level); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL mid_async_level got=%0d exp=0", level); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_async_ready got=%b exp=0", in_ready); end
        checks++; if (hwm !== 5'd0) begin failures++; $display("FAIL mid_async_hwm got=%0d exp=0", hwm); end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL mid_rel_level got=%0d exp=0", level); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rel_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rel_ready got=%b exp=1", in_ready); end
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 8'h77) begin failures++; $display("FAIL mid_after_data got=%h exp=77", out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL mid_after_level got=%0d exp=0", level); end
    endtask

    task automatic test_hwm();
        hwm_clear = 1'b1;
        step();
        hwm_clear = 1'b0;
        checks++; if (hwm !== 5'd0) begin failures++; $display("FAIL hwm_clear0 got=%0d exp=0", hwm); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hC0 + i);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        out_ready = 1'b0;
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL hwm_drained got=%0d exp=0", level); end
        checks++; if (hwm !== 5'(HWM_ON * 10)) begin failures++; $display("FAIL hwm_peak got=%0d exp=%0d", hwm, HWM_ON * 10); end
        in_valid = 1'b1;
        in_data  = 8'hD0;
        step();
        in_valid = 1'b0;
        checks++; if (hwm !== 5'(HWM_ON * 10)) begin failures++; $display("FAIL hwm_hold got=%0d exp=%0d", hwm, HWM_ON * 10); end
        // Clear wins even though level is nonzero: reload with count_next
        hwm_clear = 1'b1;
        step();
        hwm_clear = 1'b0;
        checks++; if (hwm !== 5'(HWM_ON)) begin failures++; $display("FAIL hwm_reload got=%0d exp=%0d", hwm, HWM_ON); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        hwm_clear = 1'b1;
        step();
        hwm_clear = 1'b0;
        checks++; if (hwm !== 5'd0) begin failures++; $display("FAIL hwm_clear got=%0d exp=0", hwm); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_latency();
        test_fill_drain();
        test_back_to_back();
        test_random_stream();
        test_reset_mid();
        test_hwm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
